// File: rtl/rotary_value_ctrl.sv
// Turns quadrature decoder step strobes into a bounded setting register with
// velocity acceleration, clamp/wrap at the limits and a decoder-error lockout.
module rotary_value_ctrl #(
  parameter int VALUE_WIDTH = 8,
  parameter int VALUE_MIN   = 0,
  parameter int VALUE_MAX   = 255,
  parameter int VALUE_INIT  = 0,
  parameter int WRAP        = 0,
  parameter int FAST_WINDOW = 1000,
  parameter int FAST_COUNT  = 3,
  parameter int FAST_STEP   = 4,
  parameter int ERR_LIMIT   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cnt,
  input  logic                   i_cnt_cw,
  input  logic                   i_cnt_err,
  input  logic                   i_load,
  input  logic [VALUE_WIDTH-1:0] iv_load_value,
  output logic [VALUE_WIDTH-1:0] ov_value,
  output logic                   o_changed,
  output logic                   o_at_min,
  output logic                   o_at_max,
  output logic                   o_fast,
  output logic                   o_locked
);
  localparam int EXT = VALUE_WIDTH + 2;
  localparam int TW  = $clog2(FAST_WINDOW + 1);
  localparam int SW  = $clog2(FAST_COUNT + 1);
  localparam int EW  = $clog2(ERR_LIMIT + 1);
  localparam int LW  = $clog2(LOCK_CYCLES + 1);

  localparam logic [EXT-1:0]         MIN_X     = EXT'(VALUE_MIN);
  localparam logic [EXT-1:0]         MAX_X     = EXT'(VALUE_MAX);
  localparam logic [EXT-1:0]         STEP_X    = EXT'(FAST_STEP);
  localparam logic [EXT-1:0]         ONE_X     = EXT'(1);
  localparam logic [TW-1:0]          WIN       = TW'(FAST_WINDOW);
  localparam logic [SW-1:0]          CNT_FAST  = SW'(FAST_COUNT);
  localparam logic [EW-1:0]          ERR_MAX   = EW'(ERR_LIMIT);
  localparam logic [LW-1:0]          LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [VALUE_WIDTH-1:0] INIT_V    = VALUE_WIDTH'(VALUE_INIT);

  typedef enum logic [1:0] {SLOW, FAST, LOCK} state_t;

  state_t                 state_reg, state_next;
  logic [VALUE_WIDTH-1:0] value_reg;
  logic                   changed_reg, at_min_reg, at_max_reg;
  logic [TW-1:0]          timer_reg, timer_next;
  logic [SW-1:0]          streak_reg, streak_next;
  logic [EW-1:0]          err_reg, err_next;
  logic                   dir_reg, dir_next;
  logic [LW-1:0]          lock_cnt_reg, lock_cnt_next;

  logic           accept, err_evt, same_dir;
  logic [EXT-1:0] cur_x, size_x, load_x, up_x, down_floor_x, result_x;

  assign accept       = i_cnt && !i_cnt_err && !i_load && (state_reg != LOCK);
  assign err_evt      = i_cnt_err && (state_reg != LOCK);
  assign same_dir     = (i_cnt_cw == dir_reg);
  assign cur_x        = EXT'(value_reg);
  assign load_x       = EXT'(iv_load_value);
  assign size_x       = (state_reg == FAST && same_dir) ? STEP_X : ONE_X;
  assign up_x         = cur_x + size_x;
  // v - s < MIN is tested as v < MIN + s so nothing goes negative
  assign down_floor_x = MIN_X + size_x;

  always_comb begin
    result_x = cur_x;
    if (i_load) begin
      if (load_x < MIN_X)      result_x = MIN_X;
      else if (load_x > MAX_X) result_x = MAX_X;
      else                     result_x = load_x;
    end else if (accept) begin
      if (i_cnt_cw) begin
        if (up_x <= MAX_X)  result_x = up_x;
        else if (WRAP != 0) result_x = MIN_X + (up_x - MAX_X - ONE_X);
        else                result_x = MAX_X;
      end else begin
        if (cur_x >= down_floor_x) result_x = cur_x - size_x;
        else if (WRAP != 0)        result_x = MAX_X - (down_floor_x - cur_x - ONE_X);
        else                       result_x = MIN_X;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = (timer_reg == WIN) ? timer_reg : timer_reg + TW'(1);
    streak_next   = streak_reg;
    err_next      = err_reg;
    dir_next      = dir_reg;
    lock_cnt_next = lock_cnt_reg;

    if (accept) begin
      timer_next = '0;
      dir_next   = i_cnt_cw;
      err_next   = '0;
      if (timer_reg < WIN && same_dir)
        streak_next = (streak_reg == CNT_FAST) ? streak_reg : streak_reg + SW'(1);
      else
        streak_next = SW'(1);
    end
    if (err_evt && err_reg != ERR_MAX)
      err_next = err_reg + EW'(1);

    case (state_reg)
      SLOW: begin
        if (err_evt && err_next == ERR_MAX) begin
          state_next    = LOCK;
          lock_cnt_next = '0;
        end else if (accept && streak_next == CNT_FAST) begin
          state_next = FAST;
        end
      end
      FAST: begin
        if (err_evt && err_next == ERR_MAX) begin
          state_next    = LOCK;
          lock_cnt_next = '0;
        end else if (accept && !same_dir) begin
          state_next = SLOW;
        end else if (!accept && timer_next == WIN) begin
          state_next  = SLOW;
          streak_next = '0;
        end
      end
      LOCK: begin
        if (lock_cnt_reg == LOCK_LAST) begin
          state_next  = SLOW;
          streak_next = '0;
          err_next    = '0;
          timer_next  = WIN;
        end else begin
          lock_cnt_next = lock_cnt_reg + LW'(1);
        end
      end
      default: state_next = SLOW;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= SLOW;
      value_reg    <= INIT_V;
      changed_reg  <= 1'b0;
      at_min_reg   <= (VALUE_INIT == VALUE_MIN);
      at_max_reg   <= (VALUE_INIT == VALUE_MAX);
      timer_reg    <= WIN;
      streak_reg   <= '0;
      err_reg      <= '0;
      dir_reg      <= 1'b1;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      value_reg    <= result_x[VALUE_WIDTH-1:0];
      changed_reg  <= (result_x[VALUE_WIDTH-1:0] != value_reg);
      at_min_reg   <= (result_x == MIN_X);
      at_max_reg   <= (result_x == MAX_X);
      timer_reg    <= timer_next;
      streak_reg   <= streak_next;
      err_reg      <= err_next;
      dir_reg      <= dir_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  assign ov_value  = value_reg;
  assign o_changed = changed_reg;
  assign o_at_min  = at_min_reg;
  assign o_at_max  = at_max_reg;
  assign o_fast    = (state_reg == FAST);
  assign o_locked  = (state_reg == LOCK);
endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Scoreboard bench: clamp and wrap instances share stimulus; a cycle-level
// reference model queues expected outputs and a monitor compares them.
`timescale 1ns/1ps
module tb_rotary_value_ctrl;
  localparam int VW = 4, VMIN = 2, VMAX = 12, VINIT = 5;
  localparam int FW = 8, FC = 3, FS = 4, EL = 2, LC = 10;
  localparam int RANGE = VMAX - VMIN + 1;
  localparam int SLOW_M = 0, FAST_M = 1, LOCK_M = 2;

  logic clk = 1'b0;
  logic rst, cnt, cw, err, ld;
  logic [VW-1:0] lv;
  logic [VW-1:0] value_c, value_w;
  logic changed_c, at_min_c, at_max_c, fast_c, locked_c;
  logic changed_w, at_min_w, at_max_w, fast_w, locked_w;

  always #5 clk = ~clk;

  rotary_value_ctrl #(.VALUE_WIDTH(VW), .VALUE_MIN(VMIN), .VALUE_MAX(VMAX), .VALUE_INIT(VINIT),
    .WRAP(0), .FAST_WINDOW(FW), .FAST_COUNT(FC), .FAST_STEP(FS), .ERR_LIMIT(EL),
    .LOCK_CYCLES(LC)) dut_clamp (
    .i_clk(clk), .i_reset(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(err), .i_load(ld),
    .iv_load_value(lv), .ov_value(value_c), .o_changed(changed_c), .o_at_min(at_min_c),
    .o_at_max(at_max_c), .o_fast(fast_c), .o_locked(locked_c));

  rotary_value_ctrl #(.VALUE_WIDTH(VW), .VALUE_MIN(VMIN), .VALUE_MAX(VMAX), .VALUE_INIT(VINIT),
    .WRAP(1), .FAST_WINDOW(FW), .FAST_COUNT(FC), .FAST_STEP(FS), .ERR_LIMIT(EL),
    .LOCK_CYCLES(LC)) dut_wrap (
    .i_clk(clk), .i_reset(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_cnt_err(err), .i_load(ld),
    .iv_load_value(lv), .ov_value(value_w), .o_changed(changed_w), .o_at_min(at_min_w),
    .o_at_max(at_max_w), .o_fast(fast_w), .o_locked(locked_w));

  // last_step is the edge index of the last accepted step; interval = edges since then
  typedef struct {
    int value; bit changed; int mode; int last_step; int streak; int errs; bit dir; int lock_left;
  } mstate_t;
  typedef struct { int value; bit changed; bit at_min; bit at_max; bit fast; bit locked; } exp_t;

  mstate_t m_c, m_w;
  exp_t q_c[$], q_w[$];
  int edge_no = 0;
  int mon_no = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic mstate_t model_init();
    mstate_t m;
    m.value = VINIT; m.changed = 1'b0; m.mode = SLOW_M; m.last_step = -100000;
    m.streak = 0; m.errs = 0; m.dir = 1'b1; m.lock_left = 0;
    return m;
  endfunction

  function automatic int clampi(input int x);
    return (x < VMIN) ? VMIN : ((x > VMAX) ? VMAX : x);
  endfunction

  function automatic void model_tick(inout mstate_t m, input bit wrap, input int k,
                                     input bit r, input bit c, input bit d, input bit e,
                                     input bit l, input int lval, output exp_t x);
    int old, tmr, size, target;
    bit acc, eev, rev;
    if (r) begin
      m = model_init();
    end else begin
      old = m.value;
      acc = c && !e && !l && (m.mode != LOCK_M);
      eev = e && (m.mode != LOCK_M);
      tmr = k - m.last_step - 1;
      if (tmr > FW) tmr = FW;
      rev = (d != m.dir);
      if (l) begin
        m.value = clampi(lval);
      end else if (acc) begin
        size = (m.mode == FAST_M && !rev) ? FS : 1;
        target = d ? m.value + size : m.value - size;
        if (wrap) m.value = VMIN + (((target - VMIN) % RANGE) + RANGE) % RANGE;
        else      m.value = clampi(target);
      end
      m.changed = (m.value != old);
      if (m.mode == LOCK_M) begin
        m.lock_left--;
        if (m.lock_left == 0) begin
          m.mode = SLOW_M; m.streak = 0; m.errs = 0; m.last_step = -100000;
        end
      end else if (acc) begin
        m.streak = (tmr < FW && !rev) ? ((m.streak < FC) ? m.streak + 1 : FC) : 1;
        m.dir = d; m.last_step = k; m.errs = 0;
        if (m.mode == SLOW_M && m.streak == FC) m.mode = FAST_M;
        else if (m.mode == FAST_M && rev)       m.mode = SLOW_M;
      end else begin
        if (eev && m.errs < EL) m.errs++;
        if (eev && m.errs == EL) begin
          m.mode = LOCK_M; m.lock_left = LC;
        end else if (m.mode == FAST_M && (k - m.last_step) >= FW) begin
          m.mode = SLOW_M; m.streak = 0;
        end
      end
    end
    x.value = m.value; x.changed = m.changed;
    x.at_min = (m.value == VMIN); x.at_max = (m.value == VMAX);
    x.fast = (m.mode == FAST_M); x.locked = (m.mode == LOCK_M);
  endfunction

  task automatic drive(input bit r, input bit c, input bit d, input bit e, input bit l,
                       input int lval);
    exp_t x;
    rst = r; cnt = c; cw = d; err = e; ld = l; lv = VW'(lval);
    model_tick(m_c, 1'b0, edge_no, r, c, d, e, l, lval, x); q_c.push_back(x);
    model_tick(m_w, 1'b1, edge_no, r, c, d, e, l, lval, x); q_w.push_back(x);
    edge_no++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic step(input bit d);
    drive(1'b0, 1'b1, d, 1'b0, 1'b0, 0);
  endtask

  task automatic check(input string tag, input exp_t x, input logic [VW-1:0] v,
                       input logic ch, input logic mn, input logic mx, input logic f,
                       input logic lk);
    vectors++;
    if (v !== VW'(x.value) || ch !== x.changed || mn !== x.at_min || mx !== x.at_max ||
        f !== x.fast || lk !== x.locked) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got value=%0d changed=%b min=%b max=%b fast=%b locked=%b, want value=%0d changed=%b min=%b max=%b fast=%b locked=%b",
               tag, mon_no, v, ch, mn, mx, f, lk,
               x.value, x.changed, x.at_min, x.at_max, x.fast, x.locked);
    end
  endtask

  initial begin
    exp_t xc, xw;
    forever begin
      @(negedge clk);
      if (q_c.size() > 0 && q_w.size() > 0) begin
        xc = q_c.pop_front();
        xw = q_w.pop_front();
        check("clamp", xc, value_c, changed_c, at_min_c, at_max_c, fast_c, locked_c);
        check("wrap", xw, value_w, changed_w, at_min_w, at_max_w, fast_w, locked_w);
        $display("cycle %0d: clamp value=%0d fast=%b locked=%b | wrap value=%0d fast=%b locked=%b",
                 mon_no, value_c, fast_c, locked_c, value_w, fast_w, locked_w);
        mon_no++;
      end
    end
  end

  initial begin
    bit d;
    int n, gap, roll;
    rst = 1'b1; cnt = 1'b0; cw = 1'b0; err = 1'b0; ld = 1'b0; lv = '0;
    m_c = model_init(); m_w = model_init();

    // slow steps from reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) begin step(1'b1); idle(19); end

    // acceleration into the upper limit, then window timeout
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (5) begin step(1'b1); idle(2); end
    idle(8);

    // fast step across the top (wraps on the wrap instance), then reversal
    idle(10);
    repeat (3) begin step(1'b1); idle(2); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11);
    idle(1);
    step(1'b1);
    idle(1);
    step(1'b0);

    // error lockout, steps and errors ignored while locked
    idle(20);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    repeat (3) begin step(1'b1); idle(1); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(5);
    step(1'b1);

    // error beats step; load beats step and clamps
    idle(3);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15);
    idle(2);
    step(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // reset while fast at 9
    idle(10);
    repeat (4) begin step(1'b1); idle(2); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
    step(1'b1);
    idle(2);

    // randomized bursts
    for (int b = 0; b < 300; b++) begin
      d = 1'($urandom_range(1, 0));
      n = int'($urandom_range(6, 1));
      gap = int'($urandom_range(11, 0));
      for (int s = 0; s < n; s++) begin
        roll = int'($urandom_range(99, 0));
        if (roll >= 90) d = ~d;
        if (roll < 4)       drive(1'b0, 1'b1, d, 1'b1, 1'b0, 0);
        else if (roll < 8)  drive(1'b0, 1'b1, d, 1'b0, 1'b1, int'($urandom_range(15, 0)));
        else if (roll < 9)  drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        else if (roll < 14) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        else                step(d);
        idle(gap);
      end
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    if (q_c.size() != 0 || q_w.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0", q_c.size(), q_w.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
